// File: rtl/color_display_if.sv
// Colour stream between the game FSM (master) and the LED display (slave).
//   color_in, send_color : colour mask and its single-cycle push strobe
//   full, overflow       : FIFO status back to the game FSM
//   leds, busy, done     : display activity and end-of-playback pulse
interface color_display_if;
    logic [4:0] color_in;
    logic       send_color;
    logic       full;
    logic [4:0] leds;
    logic       busy;
    logic       done;
    logic       overflow;

    modport master (
        output color_in, send_color,
        input  full, leds, busy, done, overflow
    );

    modport slave (
        input  color_in, send_color,
        output full, leds, busy, done, overflow
    );
endinterface

// File: rtl/color_display.sv
// LED playback engine: buffers pushed colour masks in a small FIFO and shows
// each one for ON_CYCLES, followed by OFF_CYCLES of darkness. Pulses done
// once the last queued colour has finished its gap.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : colour push strobe in, LED drive / status out (slave side)
module color_display #(
    parameter int unsigned ON_CYCLES  = 12_500_000,
    parameter int unsigned OFF_CYCLES = 6_250_000,
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic           clk,
    input  logic           reset,
    color_display_if.slave bus
);
    localparam int unsigned COLOR_W = 5;
    localparam int unsigned PTR_W   = FIFO_AW + 1;
    localparam int unsigned DEPTH   = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [COLOR_W-1:0]   leds_q, leds_nxt;
    logic                 done_q, done_nxt;
    logic                 overflow_q;
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [COLOR_W-1:0]   mem [DEPTH];

    logic                 empty_c;
    logic                 full_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 cnt_zero_c;
    logic [COLOR_W-1:0]   head_c;

    // FIFO status from registered pointers; extra MSB separates full from empty
    assign empty_c    = (rd_ptr == wr_ptr);
    assign full_c     = (rd_ptr[FIFO_AW-1:0] == wr_ptr[FIFO_AW-1:0]) &&
                        (rd_ptr[FIFO_AW] != wr_ptr[FIFO_AW]);
    assign push_c     = bus.send_color && !full_c;
    assign cnt_zero_c = (cnt == '0);

    // A push into an empty FIFO on the last OFF cycle is forwarded straight to
    // the LEDs so playback continues without an IDLE detour.
    assign head_c = empty_c ? bus.color_in : mem[rd_ptr[FIFO_AW-1:0]];

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            leds_q     <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            leds_q <= leds_nxt;
            done_q <= done_nxt;
            if (bus.send_color && full_c) begin
                overflow_q <= 1'b1;
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage, not reset
    always_ff @(posedge clk) begin
        if (push_c && !reset) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= bus.color_in;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!empty_c) begin
                    state_nxt = S_ON;
                end
            end
            S_ON: begin
                if (cnt_zero_c) begin
                    state_nxt = S_OFF;
                end
            end
            S_OFF: begin
                if (cnt_zero_c) begin
                    state_nxt = (!empty_c || push_c) ? S_ON : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        pop_c    = 1'b0;
        cnt_nxt  = cnt;
        leds_nxt = leds_q;
        done_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                leds_nxt = '0;
                if (!empty_c) begin
                    pop_c    = 1'b1;
                    leds_nxt = head_c;
                    cnt_nxt  = CNT_W'(ON_CYCLES - 1);
                end
            end
            S_ON: begin
                if (cnt_zero_c) begin
                    leds_nxt = '0;
                    cnt_nxt  = CNT_W'(OFF_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_OFF: begin
                leds_nxt = '0;
                if (cnt_zero_c) begin
                    if (!empty_c || push_c) begin
                        pop_c    = 1'b1;
                        leds_nxt = head_c;
                        cnt_nxt  = CNT_W'(ON_CYCLES - 1);
                    end else begin
                        done_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                leds_nxt = '0;
                cnt_nxt  = '0;
            end
        endcase
    end

    assign bus.full     = full_c;
    assign bus.leds     = leds_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state != S_IDLE) || !empty_c;
endmodule

// File: tb/tb_color_display.sv
// Self-checking bench for color_display with ON_CYCLES=4, OFF_CYCLES=2.
// A queue-based slot model predicts leds/full/busy/done/overflow every cycle.
module tb_color_display;
    localparam int ON    = 4;
    localparam int OFF   = 2;
    localparam int DEPTH = 8;
    localparam int SLOT  = ON + OFF;

    logic clk;
    logic reset;
    color_display_if bus ();

    color_display #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .CNT_W     (3),
        .FIFO_AW   (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Reference model: a colour "slot" lasts SLOT cycles, lit for the first ON.
    logic [4:0] q[$];
    bit         m_active = 0;
    int         m_phase  = 0;
    logic [4:0] m_color  = '0;
    bit         m_done   = 0;
    bit         m_ovf    = 0;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic s, input logic [4:0] c, input logic r);
        bit pushed_ok;
        if (r) begin
            q.delete();
            m_active = 0;
            m_phase  = 0;
            m_color  = '0;
            m_done   = 0;
            m_ovf    = 0;
            return;
        end
        m_done    = 0;
        pushed_ok = s && (q.size() < DEPTH);
        if (s && q.size() >= DEPTH) m_ovf = 1;
        if (!m_active) begin
            if (q.size() > 0) begin
                m_color  = q.pop_front();
                m_active = 1;
                m_phase  = 0;
            end
        end else if (m_phase == SLOT - 1) begin
            if (q.size() > 0) begin
                m_color = q.pop_front();
                m_phase = 0;
            end else if (pushed_ok) begin
                m_color   = c;
                m_phase   = 0;
                pushed_ok = 0;
            end else begin
                m_active = 0;
                m_done   = 1;
            end
        end else begin
            m_phase++;
        end
        if (pushed_ok) q.push_back(c);
    endtask

    // One clock: compare outputs mid-cycle, then drive inputs for the next edge.
    task automatic cycle(input logic s, input logic [4:0] c, input logic r);
        logic [4:0] exp_leds;
        @(negedge clk);
        if (chk_en) begin
            exp_leds = (m_active && m_phase < ON) ? m_color : 5'd0;
            check("leds", bus.leds, exp_leds);
            check("full", {4'd0, bus.full}, {4'd0, (q.size() == DEPTH)});
            check("busy", {4'd0, bus.busy}, {4'd0, (m_active || q.size() != 0)});
            check("done", {4'd0, bus.done}, {4'd0, m_done});
            check("overflow", {4'd0, bus.overflow}, {4'd0, m_ovf});
        end
        bus.send_color = s;
        bus.color_in   = c;
        reset          = r;
        model_step(s, c, r);
        if (r) chk_en = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (!m_active && q.size() == 0) break;
            cycle(1'b0, 5'd0, 1'b0);
        end
        idle(2);
        check("drained_busy", {4'd0, bus.busy}, 5'd0);
    endtask

    initial begin
        bus.send_color = 1'b0;
        bus.color_in   = '0;
        reset          = 1'b1;

        // Reset and reset-state checks
        cycle(1'b0, 5'd0, 1'b1);
        cycle(1'b0, 5'd0, 1'b1);
        @(negedge clk);
        check("rst_leds", bus.leds, 5'd0);
        check("rst_full", {4'd0, bus.full}, 5'd0);
        check("rst_busy", {4'd0, bus.busy}, 5'd0);
        check("rst_done", {4'd0, bus.done}, 5'd0);

        // Single colour
        idle(8);
        cycle(1'b1, 5'b00100, 1'b0);
        idle(12);

        // Three-colour sequence
        cycle(1'b1, 5'b00001, 1'b0);
        cycle(1'b1, 5'b00010, 1'b0);
        cycle(1'b1, 5'b10000, 1'b0);
        drain();

        // Overflow burst: pushes outrun playback until the FIFO fills
        for (int i = 0; i < 14; i++) cycle(1'b1, 5'(i + 1), 1'b0);
        drain();
        @(negedge clk);
        check("overflow_sticky", {4'd0, bus.overflow}, 5'd1);
        cycle(1'b0, 5'd0, 1'b1);

        // Wrap-around: 20 distinct colours in bursts of 3
        for (int idx = 0; idx < 20; ) begin
            for (int k = 0; k < 3 && idx < 20; k++) begin
                cycle(1'b1, 5'(idx + 1), 1'b0);
                idx++;
            end
            idle(int'($urandom_range(0, 20)));
        end
        drain();

        // Late push in the final OFF cycle of a one-entry run
        cycle(1'b1, 5'b00011, 1'b0);
        for (int i = 0; i < 50; i++) begin
            if (m_active && m_phase == SLOT - 1 && q.size() == 0) break;
            cycle(1'b0, 5'd0, 1'b0);
        end
        cycle(1'b1, 5'b01000, 1'b0);
        drain();

        // Reset mid-ON with entries queued; a push in the reset cycle is ignored
        for (int i = 0; i < 4; i++) cycle(1'b1, 5'(5'd17 + 5'(i)), 1'b0);
        idle(1);
        cycle(1'b1, 5'b11111, 1'b1);
        idle(20);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                  5'($urandom_range(0, 31)),
                  ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
